conn_table: RTL

CONN_TABLE -- requirements
Module: conn_table

---
 rtl/conn_table_pkg.sv | 41 ++++
 rtl/conn_table_if.sv | 21 ++
 rtl/conn_table_mem.sv | 44 ++++
 rtl/conn_table.sv | 127 ++++++++++++
 4 files changed

// File: rtl/conn_table_pkg.sv
// Shared tuple layout, FSM state type and hash for the connection table and the
// upstream packet rewriter.
package conn_table_pkg;

  localparam int TUPLE_W      = 104;
  localparam int PORT_W       = 16;
  localparam int SRC_IP_LSB   = 72;
  localparam int DST_IP_LSB   = 40;
  localparam int SRC_PORT_LSB = 24;
  localparam int DST_PORT_LSB = 8;
  localparam int PROTO_LSB    = 0;

  typedef struct packed {
    logic [31:0] src_ip;
    logic [31:0] dst_ip;
    logic [15:0] src_port;
    logic [15:0] dst_port;
    logic [7:0]  protocol;
  } tuple_t;

  typedef enum logic [1:0] {
    IDLE,
    PROBE,
    RESP,
    WAIT_LOW
  } state_t;

  // XOR-fold into hash_len-bit chunks; bit i lands in position i mod hash_len,
  // which is the same as zero-extending the short final chunk. hash_len <= 16.
  function automatic logic [15:0] tuple_hash(input tuple_t t, input int hash_len);
    logic [15:0]        h;
    logic [TUPLE_W-1:0] bits;
    h    = '0;
    bits = t;
    for (int i = 0; i < TUPLE_W; i++) begin
      h[4'(i % hash_len)] = h[4'(i % hash_len)] ^ bits[i];
    end
    return h;
  endfunction

endpackage

// File: rtl/conn_table_if.sv
// Request/response bundle between a requester and the connection table.
interface conn_table_if #(
  parameter int HASH_LEN = 8
);
  logic [127:0]      tuple_data_i;
  logic              tuple_valid_i;
  logic [15:0]       conn_data_o;
  logic              conn_valid_o;
  logic [HASH_LEN:0] occupancy_o;
  logic [15:0]       full_cnt_o;

  modport master (
    output tuple_data_i, tuple_valid_i,
    input  conn_data_o, conn_valid_o, occupancy_o, full_cnt_o
  );

  modport slave (
    input  tuple_data_i, tuple_valid_i,
    output conn_data_o, conn_valid_o, occupancy_o, full_cnt_o
  );
endinterface

// File: rtl/conn_table_mem.sv
// Entry storage: combinational read, single write port, valid bits cleared by reset.
// Key/port payload is not reset; only valid bits gate its use.
module conn_table_mem
  import conn_table_pkg::*;
#(
  parameter int HASH_LEN = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [HASH_LEN-1:0] rd_addr,
  output logic                rd_valid,
  output tuple_t              rd_key,
  output logic [PORT_W-1:0]   rd_port,
  input  logic                wr_en,
  input  logic [HASH_LEN-1:0] wr_addr,
  input  tuple_t              wr_key,
  input  logic [PORT_W-1:0]   wr_port
);
  localparam int DEPTH = 1 << HASH_LEN;

  logic [DEPTH-1:0]  valid_q;
  tuple_t            key_q  [DEPTH];
  logic [PORT_W-1:0] port_q [DEPTH];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= '0;
    end else if (wr_en) begin
      valid_q[wr_addr] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      key_q[wr_addr]  <= wr_key;
      port_q[wr_addr] <= wr_port;
    end
  end

  assign rd_valid = valid_q[rd_addr];
  assign rd_key   = key_q[rd_addr];
  assign rd_port  = port_q[rd_addr];

endmodule

// File: rtl/conn_table.sv
// NAT connection table: hash + linear probe, allocates PORT_BASE+index on a miss.
// Latency 1+probes to a one-cycle response; request is level, re-armed only after it drops.
module conn_table
  import conn_table_pkg::*;
#(
  parameter int          HASH_LEN  = 8,
  parameter int          MAX_PROBE = 4,
  parameter logic [15:0] PORT_BASE = 16'hC000
) (
  input logic         clk,
  input logic         reset,
  conn_table_if.slave bus
);
  localparam int CNT_W = (MAX_PROBE > 1) ? $clog2(MAX_PROBE) : 1;

  state_t              state_q, state_d;
  logic [HASH_LEN-1:0] idx_q, idx_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  tuple_t              key_q, key_d;
  logic [PORT_W-1:0]   result_q, result_d;
  logic [HASH_LEN:0]   occ_q, occ_d;
  logic [15:0]         full_q, full_d;

  tuple_t              tuple_in;
  logic                ent_valid;
  tuple_t              ent_key;
  logic [PORT_W-1:0]   ent_port;
  logic                wr_en;
  logic [PORT_W-1:0]   alloc_port;

  assign tuple_in   = tuple_t'(TUPLE_W'(bus.tuple_data_i));
  assign alloc_port = PORT_BASE + PORT_W'(idx_q);

  conn_table_mem #(
    .HASH_LEN (HASH_LEN)
  ) u_mem (
    .clk      (clk),
    .reset    (reset),
    .rd_addr  (idx_q),
    .rd_valid (ent_valid),
    .rd_key   (ent_key),
    .rd_port  (ent_port),
    .wr_en    (wr_en),
    .wr_addr  (idx_q),
    .wr_key   (key_q),
    .wr_port  (alloc_port)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      cnt_q    <= '0;
      key_q    <= '0;
      result_q <= '0;
      occ_q    <= '0;
      full_q   <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      key_q    <= key_d;
      result_q <= result_d;
      occ_q    <= occ_d;
      full_q   <= full_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    key_d    = key_q;
    result_d = result_q;
    occ_d    = occ_q;
    full_d   = full_q;
    wr_en    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.tuple_valid_i) begin
          key_d   = tuple_in;
          idx_d   = HASH_LEN'(tuple_hash(tuple_in, HASH_LEN));
          cnt_d   = '0;
          state_d = PROBE;
        end
      end
      PROBE: begin
        if (ent_valid && (ent_key == key_q)) begin
          result_d = ent_port;
          state_d  = RESP;
        end else if (!ent_valid) begin
          wr_en    = 1'b1;
          result_d = alloc_port;
          occ_d    = occ_q + (HASH_LEN+1)'(1);
          state_d  = RESP;
        end else if (cnt_q == CNT_W'(MAX_PROBE - 1)) begin
          // Probe budget exhausted: pass the original port through untranslated.
          result_d = key_q.src_port;
          if (full_q != 16'hFFFF) begin
            full_d = full_q + 16'd1;
          end
          state_d = RESP;
        end else begin
          idx_d = idx_q + HASH_LEN'(1);
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RESP: begin
        state_d = WAIT_LOW;
      end
      WAIT_LOW: begin
        if (!bus.tuple_valid_i) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.conn_valid_o = (state_q == RESP);
  assign bus.conn_data_o  = result_q;
  assign bus.occupancy_o  = occ_q;
  assign bus.full_cnt_o   = full_q;

endmodule
